// File: rtl/mux2_1_rr_pkg.sv
// Shared select-tag constants for the 2-to-1 round-robin stream combiner.
// The tag values match the select input of the companion 1-to-2 demultiplexer.
package mux_pkg;

   localparam logic SEL_CH0 = 1'b0;
   localparam logic SEL_CH1 = 1'b1;

   // Reset to ch1 so that ch0 wins the first contention after reset.
   localparam logic LAST_GRANT_RST = SEL_CH1;

endpackage : mux_pkg

// File: rtl/mux2_1_rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational.
// On contention, the requester that did not win the last transfer is granted.
import mux_pkg::*;

module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic gnt0,
   output logic gnt1
);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (req0 && req1) begin
         gnt0 = (last == SEL_CH1);
         gnt1 = (last == SEL_CH0);
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
   end

endmodule : rr_arb2

// File: rtl/mux2_1_rr.sv
// Two-channel valid/ready combiner: round-robin arbitration into a one-entry
// tagged output buffer, plus saturating per-channel beat counters.
import mux_pkg::*;

module mux2_1_rr #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i0_data,
   input  logic             i0_valid,
   output logic             i0_ready,
   input  logic [WIDTH-1:0] i1_data,
   input  logic             i1_valid,
   output logic             i1_ready,
   output logic [WIDTH-1:0] y_data,
   output logic             y_sel,
   output logic             y_valid,
   input  logic             y_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic [WIDTH-1:0] y_data_reg;
   logic             y_sel_reg;
   logic             y_valid_reg;
   logic             last_grant_reg;
   logic [CNT_W-1:0] cnt_reg [2];

   logic             load_en;
   logic             gnt0;
   logic             gnt1;
   logic [1:0]       take;

   rr_arb2 u_arb (
      .req0 (i0_valid),
      .req1 (i1_valid),
      .last (last_grant_reg),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );

   // Buffer refills in the same cycle it drains; readies stay low during reset.
   assign load_en  = !y_valid_reg || y_ready;
   assign i0_ready = rst_n & load_en & gnt0;
   assign i1_ready = rst_n & load_en & gnt1;
   assign take     = {i1_valid & i1_ready, i0_valid & i0_ready};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_data_reg     <= '0;
         y_sel_reg      <= SEL_CH0;
         y_valid_reg    <= 1'b0;
         last_grant_reg <= LAST_GRANT_RST;
      end else if (take[0]) begin
         y_data_reg     <= i0_data;
         y_sel_reg      <= SEL_CH0;
         y_valid_reg    <= 1'b1;
         last_grant_reg <= SEL_CH0;
      end else if (take[1]) begin
         y_data_reg     <= i1_data;
         y_sel_reg      <= SEL_CH1;
         y_valid_reg    <= 1'b1;
         last_grant_reg <= SEL_CH1;
      end else if (y_ready) begin
         // Drain without refill: data and tag keep their stale values.
         y_valid_reg    <= 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               cnt_reg[gi] <= '0;
            end else if (take[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
               cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
         end
      end
   endgenerate

   assign y_data  = y_data_reg;
   assign y_sel   = y_sel_reg;
   assign y_valid = y_valid_reg;
   assign cnt0    = cnt_reg[0];
   assign cnt1    = cnt_reg[1];

endmodule : mux2_1_rr

// File: tb/tb_mux2_1_rr.sv
// Scoreboard bench for mux2_1_rr: directed scenarios followed by random traffic,
// checked against a transaction-level model of the combiner.
module tb_mux2_1_rr;

   localparam int WIDTH   = 8;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] i0_data = '0;
   logic             i0_valid = 1'b0;
   logic             i0_ready;
   logic [WIDTH-1:0] i1_data = '0;
   logic             i1_valid = 1'b0;
   logic             i1_ready;
   logic [WIDTH-1:0] y_data;
   logic             y_sel;
   logic             y_valid;
   logic             y_ready = 1'b0;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   mux2_1_rr #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i0_data  (i0_data),
      .i0_valid (i0_valid),
      .i0_ready (i0_ready),
      .i1_data  (i1_data),
      .i1_valid (i1_valid),
      .i1_ready (i1_ready),
      .y_data   (y_data),
      .y_sel    (y_sel),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .cnt0     (cnt0),
      .cnt1     (cnt1)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: buffer occupancy, who was served last, beats per channel.
   bit  m_known = 0;
   bit  m_full  = 0;
   int  m_last  = 1;
   int  m_cnt [2] = '{0, 0};
   logic [WIDTH:0] exp_q [$];   // {sel, data} in expected output order

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, then
   // advance the model at the posedge.
   task automatic step(input bit rn, input bit v0, input logic [WIDTH-1:0] d0,
                       input bit v1, input logic [WIDTH-1:0] d1, input bit yr);
      int  win;
      bit  can_load;
      @(negedge clk);
      rst_n = rn; i0_valid = v0; i0_data = d0; i1_valid = v1; i1_data = d1; y_ready = yr;
      #1;
      can_load = !m_full || yr;
      if (v0 && v1)  win = 1 - m_last;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
      else           win = -1;
      if (!rn || !can_load) win = -1;
      check("i0_ready", 32'(i0_ready), 32'(win == 0));
      check("i1_ready", 32'(i1_ready), 32'(win == 1));
      if (m_known) begin
         check("y_valid", 32'(y_valid), 32'(m_full));
         check("cnt0", 32'(cnt0), 32'(m_cnt[0]));
         check("cnt1", 32'(cnt1), 32'(m_cnt[1]));
      end
      if (win >= 0) exp_q.push_back({win[0], (win == 0) ? d0 : d1});
      $display("cyc t=%0t rst_n=%0b v=%0b%0b d0=%02h d1=%02h yr=%0b win=%0d",
               $time, rn, v1, v0, d0, d1, yr, win);
      @(posedge clk);
      if (!rn) begin
         m_known = 1; m_full = 0; m_last = 1; m_cnt = '{0, 0};
         exp_q.delete();
      end else if (win >= 0) begin
         m_full = 1; m_last = win;
         if (m_cnt[win] < CNT_MAX) m_cnt[win]++;
      end else if (yr) begin
         m_full = 0;
      end
   endtask

   // Monitor: whenever the DUT hands a beat downstream, compare with the queue head.
   always @(negedge clk) begin
      logic [WIDTH:0] e;
      #2;
      if (m_known && rst_n && y_valid && y_ready) begin
         if (exp_q.size() == 0) begin
            check("beat_unexpected", {23'd0, y_sel, y_data}, 32'h1ff);
         end else begin
            e = exp_q.pop_front();
            check("y_sel", 32'(y_sel), 32'(e[WIDTH]));
            check("y_data", 32'(y_data), 32'(e[WIDTH-1:0]));
         end
      end
   end

   initial begin
      // Reset held with both channels requesting.
      step(0, 1, 8'h55, 1, 8'h66, 1);
      step(0, 1, 8'h55, 1, 8'h66, 1);
      // First contention after reset goes to ch0.
      step(1, 1, 8'h55, 1, 8'h66, 1);
      step(1, 0, 8'h00, 0, 8'h00, 1);
      // Reset again, then ch0-only stream.
      step(0, 0, 8'h00, 0, 8'h00, 1);
      step(1, 1, 8'h11, 0, 8'h00, 1);
      step(1, 1, 8'h22, 0, 8'h00, 1);
      step(1, 1, 8'h33, 0, 8'h00, 1);
      step(1, 0, 8'h00, 0, 8'h00, 1);
      // Continuous contention: grants alternate.
      step(0, 0, 8'h00, 0, 8'h00, 1);
      for (int i = 0; i < 6; i++) step(1, 1, 8'hA0 + 8'(i), 1, 8'hB0 + 8'(i), 1);
      step(1, 0, 8'h00, 0, 8'h00, 1);
      // Stall with both valid, then release.
      step(1, 1, 8'hC0, 1, 8'hD0, 1);
      for (int i = 0; i < 3; i++) step(1, 1, 8'hC1, 1, 8'hD1, 0);
      step(1, 1, 8'hC2, 1, 8'hD2, 1);
      step(1, 0, 8'h00, 0, 8'h00, 1);
      // Counter saturation on ch1 while data keeps flowing.
      for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 1, 8'hE0 + 8'(i), 1);
      step(1, 0, 8'h00, 1, 8'hE8, 1);
      step(1, 0, 8'h00, 0, 8'h00, 1);
      // Reset while the buffer is stalled full, then contention.
      step(1, 0, 8'h00, 1, 8'hF1, 0);
      step(1, 0, 8'h00, 1, 8'hF2, 0);
      step(0, 0, 8'h00, 1, 8'hF3, 0);
      step(1, 1, 8'h71, 1, 8'h72, 1);
      step(1, 0, 8'h00, 0, 8'h00, 1);
      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 59) != 0),
              ($urandom_range(0, 3) != 0), 8'($urandom),
              ($urandom_range(0, 3) != 0), 8'($urandom),
              ($urandom_range(0, 2) != 0));
      end
      step(1, 0, 8'h00, 0, 8'h00, 1);
      step(1, 0, 8'h00, 0, 8'h00, 1);
      check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mux2_1_rr

// File: doc/mux2_1_rr.md
Name: mux2_1_rr

Overview:
- Two-channel stream combiner with round-robin arbitration. It is the merge-side counterpart of the 1-to-2 demultiplexer.
- Each cycle it selects at most one of two valid/ready input channels and registers the beat into a one-entry output buffer. The buffer carries a select tag, so a downstream 1-to-2 demux can route the beat back by channel.
- It also keeps saturating per-channel beat counters for debug.

Parameters:
- WIDTH, 8, data width of each channel and of the output.
- CNT_W, 8, width of each per-channel beat counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on rising edge of clk.
- i0_data  input  WIDTH  channel 0 data.
- i0_valid  input  1  channel 0 data valid.
- i0_ready  output  1  channel 0 beat accepted this cycle (combinational).
- i1_data  input  WIDTH  channel 1 data.
- i1_valid  input  1  channel 1 data valid.
- i1_ready  output  1  channel 1 beat accepted this cycle (combinational).
- y_data  output  WIDTH  registered output data.
- y_sel  output  1  source tag of y_data (0 = ch0, 1 = ch1); same meaning as the demux select s.
- y_valid  output  1  output buffer holds a beat.
- y_ready  input  1  downstream accepts the beat.
- cnt0  output  CNT_W  beats accepted from ch0, saturating.
- cnt1  output  CNT_W  beats accepted from ch1, saturating.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - y_valid = 0, y_data = 0, y_sel = 0, cnt0 = 0, cnt1 = 0.
  - last_grant = 1, so ch0 wins the first contention.
  - Reset mid-transfer discards the buffered beat; no ready is asserted while rst_n = 0.
- Load enable: load_en = !y_valid | y_ready. The buffer may refill in the same cycle it drains, giving full throughput of 1 beat/cycle.
- Arbitration (combinational, in rr_arb2):
  - Only i0_valid: grant ch0.
  - Only i1_valid: grant ch1.
  - Both valid: grant the channel != last_grant.
  - Neither valid: no grant.
- Ready outputs: i0_ready = load_en & grant0; i1_ready = load_en & grant1. They are never both 1.
  - A ready may depend combinationally on y_ready.
  - An input must not make valid depend on its ready.
- On a transfer (ix_valid & ix_ready) at a clk edge:
  - y_data <= ix_data, y_sel <= x, y_valid <= 1, last_grant <= x.
  - cntx increments unless it is at all-ones, in which case it holds.
- Drain without refill (y_valid & y_ready, no grant): y_valid <= 0; y_data and y_sel hold their stale value.
- Stall (y_valid & !y_ready): y_data, y_sel and y_valid hold. Both readies are 0.
- Latency: an accepted input beat appears on y_* the cycle after acceptance.
- Ordering: the output sequence equals the grant order. No beat is duplicated or dropped, except at reset.
- last_grant updates only on an actual transfer. Idle cycles and stalls do not rotate priority.
- Fairness: under continuous contention, grants alternate 0,1,0,1,...

Decomposition:
- Package mux_pkg holds:
  - constants SEL_CH0 = 1'b0 and SEL_CH1 = 1'b1;
  - the reset value of last_grant (SEL_CH1).
- Sub-module rr_arb2 is purely combinational:
  - inputs req0, req1, last;
  - outputs gnt0, gnt1.
- The top level holds the output buffer, last_grant and the counters.

Test Plan:
- Reset with i0_valid = i1_valid = 1 held and rst_n = 0 for 2 cycles -> i0_ready = i1_ready = 0, y_valid = 0, cnt0 = cnt1 = 0. Release -> first beat on y has y_sel = 0.
- Only ch0 valid, data 0x11, 0x22, 0x33 on consecutive cycles, y_ready = 1 -> y_data is 0x11, 0x22, 0x33 one cycle later, y_sel = 0, cnt0 = 3.
- Both valid continuously for 6 cycles (ch0 = 0xA0.., ch1 = 0xB0..), y_ready = 1 -> y_sel = 0,1,0,1,0,1, cnt0 = cnt1 = 3, no beat lost.
- Stall: y_valid = 1 and y_ready = 0 for 3 cycles with both inputs valid -> y_data stable, both readies 0. Raise y_ready -> the next grant goes to the channel opposite the held y_sel.
- Saturation with CNT_W = 2: 5 beats on ch1 -> cnt1 = 3 and stays 3, while the data path keeps flowing.
- Reset mid-stream with y_valid = 1 and y_ready = 0 -> y_valid = 0 the next cycle, the buffered beat is dropped, and ch0 has priority on the next contention.
